ifetch_queue: RTL

In-order instruction prefetch queue between the PC-generation stage (ifu) and decode. It accepts fetch PCs from the ifu through a valid/ready handshake and issues word reads to instruction memory. Returned instructions are buffered in a DEPTH-entry ring together with their PCs and handed to decode through a second valid/ready handshake. A redirect (Flush) empties the queue and discards every read still in flight.

---
 rtl/ifetch_queue.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - in-order instruction prefetch queue between PC generation and decode
// Grants allocate a ring slot, in-order read responses fill it, decode pops it; Flush drops in-flight reads.
module ifetch_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ReqValid,
   input  logic [XLEN-1:0] ReqPC,
   output logic            ReqReady,
   output logic            MemReq,
   output logic [XLEN-1:0] MemAdr,
   input  logic            MemGnt,
   input  logic            MemRValid,
   input  logic [XLEN-1:0] MemRData,
   input  logic            MemRErr,
   input  logic            Flush,
   output logic            InstrValid,
   output logic [XLEN-1:0] Instr,
   output logic [XLEN-1:0] InstrPC,
   output logic            InstrFault,
   input  logic            InstrReady
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW:0]   C_DEPTH = (PW+1)'(DEPTH);
   localparam logic [PW-1:0] C_ONE   = PW'(1);

   logic [PW-1:0]   r_alloc;
   logic [PW-1:0]   r_fill;
   logic [PW-1:0]   r_head;
   logic [PW-1:0]   r_drop;
   logic [XLEN-1:0] r_pc    [DEPTH];
   logic [XLEN-1:0] r_instr [DEPTH];
   logic [DEPTH-1:0] r_fault;
   logic [DEPTH-1:0] r_filled;

   logic [PW-1:0] w_count;
   logic [PW-1:0] w_outstanding;
   logic [PW:0]   w_budget;
   logic [PW-1:0] w_drop_sum;
   logic [PW-1:0] w_drop_flush;
   logic          w_credit;
   logic          w_grant;
   logic          w_pop;
   logic          w_rsp_drop;
   logic          w_rsp_keep;
   logic [AW-1:0] w_alloc_idx;
   logic [AW-1:0] w_fill_idx;
   logic [AW-1:0] w_head_idx;

   assign w_alloc_idx   = r_alloc[AW-1:0];
   assign w_fill_idx    = r_fill[AW-1:0];
   assign w_head_idx    = r_head[AW-1:0];
   assign w_count       = r_alloc - r_head;
   assign w_outstanding = r_alloc - r_fill;

   // Reads already abandoned by a flush still occupy imem, so they count against credit.
   assign w_budget = {1'b0, w_count} + {1'b0, r_drop};
   assign w_credit = reset && !Flush && (w_budget < C_DEPTH);

   assign MemReq   = ReqValid && w_credit;
   assign MemAdr   = {ReqPC[XLEN-1:2], 2'b00};
   assign ReqReady = MemReq && MemGnt;
   assign w_grant  = ReqReady;

   assign w_rsp_drop = MemRValid && (r_drop != '0);
   assign w_rsp_keep = MemRValid && (r_drop == '0) && (w_outstanding != '0);

   // A response arriving in the flush cycle retires one of the reads being dropped.
   assign w_drop_sum   = r_drop + w_outstanding;
   assign w_drop_flush = (MemRValid && (w_drop_sum != '0)) ? (w_drop_sum - C_ONE) : w_drop_sum;

   assign InstrValid = reset && !Flush && (w_count != '0) && r_filled[w_head_idx];
   assign Instr      = r_instr[w_head_idx];
   assign InstrPC    = r_pc[w_head_idx];
   assign InstrFault = r_fault[w_head_idx];
   assign w_pop      = InstrValid && InstrReady;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_alloc  <= '0;
         r_fill   <= '0;
         r_head   <= '0;
         r_drop   <= '0;
         r_fault  <= '0;
         r_filled <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_pc[i]    <= '0;
            r_instr[i] <= '0;
         end
      end else if (Flush) begin
         r_alloc  <= '0;
         r_fill   <= '0;
         r_head   <= '0;
         r_drop   <= w_drop_flush;
         r_filled <= '0;
      end else begin
         if (w_grant) begin
            r_pc[w_alloc_idx]     <= ReqPC;
            r_filled[w_alloc_idx] <= 1'b0;
            r_alloc               <= r_alloc + C_ONE;
         end
         if (w_rsp_drop) begin
            r_drop <= r_drop - C_ONE;
         end
         if (w_rsp_keep) begin
            r_instr[w_fill_idx]  <= MemRData;
            r_fault[w_fill_idx]  <= MemRErr;
            r_filled[w_fill_idx] <= 1'b1;
            r_fill               <= r_fill + C_ONE;
         end
         if (w_pop) begin
            r_head <= r_head + C_ONE;
         end
      end
   end

endmodule
